moore_stim_ctrl: RTL
====================

# moore_stim_ctrl

Sequencing controller for the team's 3-bit Moore state machine. It accepts a serial stimulus pattern over a valid/ready handshake and resets the state machine for one cycle. It then shifts the pattern into the machine's serial input LSB-first, compares the machine's state against a target every cycle, and reports a hit count and the final state with a one-cycle `done` pulse. It sits between a host or bench sequencer and the Moore state machine, and is the only driver of that machine's `in` and reset.

## Interface
- `WIDTH`, 8: maximum pattern length in bits.
- `LEN_W`, `$clog2(WIDTH)+1`: width of the length and count fields.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `pat_valid` in 1: pattern offered.
- `pat_ready` out 1: controller can accept a pattern.
- `pat_data` in `WIDTH`: pattern bits; bit 0 is shifted first.
- `pat_len` in `LEN_W`: number of bits to shift.
- `target` in 3: state to count; sampled at accept.
- `sm_in` out 1: drives the state machine's `in`.
- `sm_rst_n` out 1: drives the state machine's active-low reset.
- `sm_state` in 3: state machine `out`.
- `done` out 1: one-cycle completion pulse.
- `hit_cnt` out `LEN_W`: count of compare cycles in which `sm_state == target`.
- `last_state` out 3: `sm_state` sampled in DRAIN.
- `abort` in 1: present only with `MOORE_CTRL_ABORT_EN`.

## Operation
- **Reset values:** state IDLE, `pat_ready=0`, `sm_in=0`, `sm_rst_n=0`, `done=0`, `hit_cnt=0`, `last_state=0`. The first cycle after reset deasserts gives `pat_ready=1` and `sm_rst_n=1`.
- **All outputs are registered.**
- **States:** IDLE, CLEAR, SHIFT, DRAIN, DONE.
- **IDLE**
  - `pat_ready=1`.
  - On `pat_valid && pat_ready`: capture `pat_data`, `target`, and `eff_len = min(pat_len, WIDTH)`.
  - Clear `hit_cnt` and `last_state`, then go to CLEAR.
  - If `eff_len==0`, go directly to DONE; `hit_cnt` and `last_state` stay 0 and `sm_rst_n` is never pulsed.
- **CLEAR:** `sm_rst_n=0` for exactly one cycle, `sm_in=0`, `pat_ready=0`. Then go to SHIFT.
- **SHIFT:**
  - `sm_in` = current LSB of the shift register; shift right each cycle.
  - A bit counter runs `0..eff_len-1`.
  - From the second SHIFT cycle on, increment `hit_cnt` when `sm_state == target`.
  - After bit `eff_len-1` is driven, go to DRAIN.
- **DRAIN:**
  - `sm_in=0`.
  - Perform the final compare, which reflects the last bit.
  - Latch `last_state = sm_state`, then go to DONE.
- **DONE:** `done=1` for one cycle, `pat_ready=0`, then go to IDLE.
- **Results:** `hit_cnt` and `last_state` hold until the next accept.
- **Counter width:** `hit_cnt` cannot overflow, since at most `WIDTH` compares are made and `LEN_W` covers `WIDTH`.
- **Changes during a run:** `pat_valid` is ignored outside IDLE. Changes on `target` or `pat_len` mid-run have no effect.
- **Reset mid-run:** returns to the reset values above in the next cycle. There is no `done` pulse, and `sm_rst_n=0` holds the state machine reset.

## Timing
- Cycle 0 is the handshake cycle.
- Cycle 1: CLEAR.
- Cycles 2 to `eff_len+1`: `sm_in` carries bits 0 to `eff_len-1`.
- Cycles 3 to `eff_len+2`: compare; cycle `eff_len+2` is DRAIN.
- Cycle `eff_len+3`: `done=1`.
- Cycle `eff_len+4`: `pat_ready=1`.
- Zero-length pattern: `done` in cycle 1, `pat_ready` in cycle 2.
- Back-to-back patterns: minimum spacing between handshakes is `eff_len+4` cycles.

## Configuration
- **Macro:** `MOORE_CTRL_ABORT_EN`.
- **With the macro defined:**
  - The `abort` port exists.
  - `abort=1` in CLEAR, SHIFT or DRAIN gives IDLE next cycle with no `done` pulse.
  - `hit_cnt` and `last_state` hold their partial values, and `sm_in=0`.
  - `abort` in IDLE or DONE is ignored.
- **Without the macro:** there is no `abort` port and no abort logic; runs always complete.

## Structure
- Shared package `moore_ctrl_pkg` holds:
  - the state enum (IDLE, CLEAR, SHIFT, DRAIN, DONE);
  - the 3-bit state-machine state width constant;
  - the `LEN_W` derivation function.
- One sub-module, `moore_ctrl_shifter`: loadable right-shift register plus bit counter, with a `last` flag.
- Compare and count logic stays in the top-level module.

## Test plan
The bench stubs the state machine as a saturating ones-counter: the state increments on `in=1` (maximum 7), clears on `in=0`, and resets on `sm_rst_n=0`.

- **Basic run:** `pat_data=8'h0F`, `len=8`, `target=3`, handshake at cycle 0. Expect `sm_in` = 1,1,1,1,0,0,0,0 in cycles 2–9, `done` in cycle 11, `hit_cnt=1`, `last_state=0`, `pat_ready=1` in cycle 12.
- **Length clamp:** `pat_data=8'hFF`, `pat_len=12`, `target=7`. Expect `eff_len=8`, `hit_cnt=2` (states 7 after bits 6 and 7), `last_state=7`, `done` in cycle 11.
- **Zero length:** `pat_len=0`. Expect `done` in cycle 1, `sm_rst_n` never low, `hit_cnt=0`, `pat_ready=1` in cycle 2.
- **Reset mid-run:** assert `reset` in cycle 5 of the basic run. Expect IDLE-reset values in cycle 6, no `done` pulse, and a clean accept of a new pattern afterwards.
- **Handshake hold-off:** keep `pat_valid=1` for the whole run. Expect exactly one accept per run, with the second accept in cycle 12.
- **Abort (`MOORE_CTRL_ABORT_EN` defined):** `abort=1` in cycle 4 of the basic run. Expect IDLE in cycle 5, `hit_cnt=0`, no `done`, `sm_in=0`.

Source files
------------

// File: rtl/moore_ctrl_pkg.sv
// Shared definitions for the Moore state-machine stimulus controller:
// controller state encoding, state-machine state width and the
// derivation of the length/count field width.
package moore_ctrl_pkg;

  localparam int SM_STATE_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SHIFT,
    ST_DRAIN,
    ST_DONE
  } ctrl_state_t;

  // One extra bit beyond log2 so the field can hold WIDTH itself.
  function automatic int calc_len_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/moore_ctrl_shifter.sv
// Loadable right-shift register with a count of bits already emitted.
// 'last' is high once every loaded bit has been emitted.
module moore_ctrl_shifter
  import moore_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = calc_len_w(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  output logic             bit_out,
  output logic [LEN_W-1:0] count,
  output logic             last
);

  logic [WIDTH-1:0] sr;
  logic [LEN_W-1:0] len;

  // Load a new pattern, or emit the LSB and advance the bit count.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr    <= '0;
      len   <= '0;
      count <= '0;
    end else if (load) begin
      sr    <= load_data;
      len   <= load_len;
      count <= '0;
    end else if (shift) begin
      sr    <= sr >> 1;
      count <= count + LEN_W'(1);
    end
  end

  assign bit_out = sr[0];
  assign last    = (count == len);

endmodule

// File: rtl/moore_stim_ctrl.sv
// Stimulus sequencer for the 3-bit Moore state machine: accepts a pattern,
// pulses the machine's reset, shifts the pattern in LSB-first, counts
// cycles where the machine state equals the target and reports the result.
// Optional feature macro: MOORE_CTRL_ABORT_EN (adds the 'abort' input).
module moore_stim_ctrl
  import moore_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = calc_len_w(WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pat_valid,
  output logic                  pat_ready,
  input  logic [WIDTH-1:0]      pat_data,
  input  logic [LEN_W-1:0]      pat_len,
  input  logic [SM_STATE_W-1:0] target,
  output logic                  sm_in,
  output logic                  sm_rst_n,
  input  logic [SM_STATE_W-1:0] sm_state,
  output logic                  done,
  output logic [LEN_W-1:0]      hit_cnt,
  output logic [SM_STATE_W-1:0] last_state
`ifdef MOORE_CTRL_ABORT_EN
  ,
  input  logic                  abort
`endif
);

  ctrl_state_t           state, state_d;
  logic                  accept;
  logic [LEN_W-1:0]      eff_len;
  logic [SM_STATE_W-1:0] target_q;
  logic                  shift_en;
  logic                  sh_bit;
  logic [LEN_W-1:0]      sh_count;
  logic                  sh_last;
  logic                  cmp_en;
  logic                  latch_last;

  assign accept  = pat_valid && pat_ready;
  assign eff_len = (pat_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : pat_len;

  moore_ctrl_shifter #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .shift     (shift_en),
    .load_data (pat_data),
    .load_len  (eff_len),
    .bit_out   (sh_bit),
    .count     (sh_count),
    .last      (sh_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  // Next-state logic; a bit is emitted whenever the next state is SHIFT.
  always_comb begin
    state_d    = state;
    shift_en   = 1'b0;
    cmp_en     = 1'b0;
    latch_last = 1'b0;
    case (state)
      ST_IDLE:  if (accept) state_d = (eff_len == '0) ? ST_DONE : ST_CLEAR;
      ST_CLEAR: state_d = ST_SHIFT;
      ST_SHIFT: if (sh_last) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
`ifdef MOORE_CTRL_ABORT_EN
    if (abort && (state == ST_CLEAR || state == ST_SHIFT || state == ST_DRAIN))
      state_d = ST_IDLE;
`endif
    shift_en   = (state_d == ST_SHIFT);
    cmp_en     = ((state == ST_SHIFT) && (sh_count > LEN_W'(1))) || (state == ST_DRAIN);
    latch_last = (state == ST_DRAIN) && (state_d == ST_DONE);
  end

  // Registered outputs derived from the next state, plus compare/count results.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_ready  <= 1'b0;
      sm_in      <= 1'b0;
      sm_rst_n   <= 1'b0;
      done       <= 1'b0;
      hit_cnt    <= '0;
      last_state <= '0;
      target_q   <= '0;
    end else begin
      pat_ready <= (state_d == ST_IDLE);
      sm_rst_n  <= (state_d != ST_CLEAR);
      done      <= (state_d == ST_DONE);
      sm_in     <= shift_en ? sh_bit : 1'b0;
      if (accept) begin
        hit_cnt    <= '0;
        last_state <= '0;
        target_q   <= target;
      end else begin
        if (cmp_en && (sm_state == target_q)) hit_cnt <= hit_cnt + LEN_W'(1);
        if (latch_last) last_state <= sm_state;
      end
    end
  end

endmodule
